pdm_capture_ctrl: RTL and testbench
===================================

PDM_CAPTURE_CTRL -- requirements
Module: pdm_capture_ctrl

Interface
REQ-001 SHALL have parameter: NUM_LINES, 4, number of shared DDR PDM data lines (two mics per line).
REQ-002 SHALL have parameter: CLK_DIV, 16, pdm_clk half-period in clk cycles (>=2).
REQ-003 SHALL have parameter: WARMUP_CYCLES, 1024, pdm_clk rising edges discarded after enable (>=1).
REQ-004 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port: rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port: enable  input  1  capture enable; level-sensitive.
REQ-007 SHALL have port: ddr_data  input  NUM_LINES  PDM data, one bit per line.
REQ-008 SHALL have port: pdm_clk  output  1  registered mic clock.
REQ-009 SHALL have port: sample_data  output  2*NUM_LINES  captured word; bit 2i = line i rising-phase mic, bit 2i+1 = line i falling-phase mic.
REQ-010 SHALL have port: sample_valid  output  1  sample_data holds an unaccepted word.
REQ-011 SHALL have port: sample_ready  input  1  downstream accepts word when high with sample_valid.
REQ-012 SHALL have port: overflow  output  1  sticky: a word was dropped.
REQ-013 SHALL have port: state  output  2  FSM state: IDLE=0, WARMUP=1, RUN=2; 3 unused.

Function
REQ-014 SHALL implement FSM IDLE -> WARMUP when enable=1; WARMUP -> RUN on the WARMUP_CYCLES-th pdm_clk rise; any state -> IDLE the cycle after enable is sampled 0.
REQ-015 SHALL hold pdm_clk=0 and divider count=0 in IDLE.
REQ-016 SHALL, in WARMUP and RUN, increment divider 0..CLK_DIV-1 and toggle pdm_clk when divider=CLK_DIV-1 (wrap to 0); period 2*CLK_DIV clk cycles, first rise CLK_DIV cycles after entering WARMUP.
REQ-017 SHALL capture ddr_data into rising-phase register on the cycle divider=CLK_DIV-1 with pdm_clk=1 (cycle before fall).
REQ-018 SHALL capture ddr_data into falling-phase register on the cycle divider=CLK_DIV-1 with pdm_clk=0 (cycle before rise), completing a word from the two registers.
REQ-019 SHALL discard all words completed in WARMUP, including one completed on the WARMUP->RUN transition edge.
REQ-020 SHALL, in RUN, load a completed word into sample_data and set sample_valid on the following cycle if sample_valid=0 or sample_ready=1 that cycle.
REQ-021 SHALL keep sample_data and sample_valid stable while sample_valid=1 and sample_ready=0.
REQ-022 SHALL clear sample_valid after a handshake cycle unless a new word loads in that same cycle (back-to-back, no overflow).
REQ-023 SHALL, when a word completes while sample_valid=1 and sample_ready=0, drop the new word and set overflow=1.
REQ-024 SHALL clear overflow only by reset or entry into IDLE.
REQ-025 SHALL, on entering IDLE, clear sample_valid and drop any pending word and partial capture; sample_data value is don't-care.
REQ-026 SHALL count warm-up rises in a counter of width clog2(WARMUP_CYCLES+1), saturating; reset to 0 on IDLE entry.

Reset
REQ-027 SHALL, when rst=0 at a clk edge, set state=IDLE, pdm_clk=0, sample_valid=0, sample_data=0, overflow=0, divider and warm-up counters=0, regardless of enable.
REQ-028 SHALL apply reset mid-operation identically; after rst=1, restart from WARMUP if enable=1 (full warm-up repeated).

Verification (CLK_DIV=2, WARMUP_CYCLES=4, NUM_LINES=4)
REQ-029 SHALL verify: reset release with enable=1 -> state=1 next cycle, pdm_clk period 4 cycles, first rise 2 cycles later, state=2 on 4th rise, no sample_valid before RUN.
REQ-030 SHALL verify: in RUN, ddr_data=4'hF during high phase, 4'h0 during low phase, sample_ready=1 -> sample_data=8'h55, sample_valid pulses 1 cycle per 4-cycle period.
REQ-031 SHALL verify: sample_ready=0 for 3 pdm periods -> first word held stable, overflow=1 after second word completes, remains 1 after sample_ready returns.
REQ-032 SHALL verify: sample_ready asserted on the same cycle a new word completes -> old accepted, new loaded, overflow stays 0.
REQ-033 SHALL verify: enable dropped in RUN with sample_valid=1 -> next cycle state=0, pdm_clk=0, sample_valid=0, overflow=0; re-enable repeats 4-rise warm-up.
REQ-034 SHALL verify: rst=0 for one cycle mid-RUN -> all outputs at REQ-027 values next cycle, warm-up restarts.

Source files
------------

// File: rtl/pdm_capture_ctrl.sv
// -----------------------------------------------------------------------------
// pdm_capture_ctrl
//
// Generates the PDM microphone clock and captures stereo-pair DDR PDM data.
// Each data line carries two microphones: one drives the line while pdm_clk is
// high (the "rising-phase" mic) and the other drives it while pdm_clk is low
// (the "falling-phase" mic). Each phase is sampled on the last system-clock
// cycle before pdm_clk changes, where the line has had the longest settle time.
// A word is complete once both phases of one pdm_clk period have been sampled.
//
// After enable, the mics are clocked for WARMUP_CYCLES pdm_clk rises with the
// output suppressed (mic start-up garbage). After that, completed words are
// offered on a valid/ready output. If a word completes while the previous one
// is still unaccepted, the new word is dropped and the sticky overflow flag
// is set.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active low
//   enable        capture enable (level); low returns to IDLE next cycle
//   ddr_data      PDM data, one bit per shared line
//   pdm_clk       registered microphone clock
//   sample_data   captured word: bit 2i = line i rising-phase mic,
//                 bit 2i+1 = line i falling-phase mic
//   sample_valid  sample_data holds an unaccepted word
//   sample_ready  downstream accepts the word when high with sample_valid
//   overflow      sticky: a completed word was dropped
//   state         FSM state: 0 IDLE, 1 WARMUP, 2 RUN
// -----------------------------------------------------------------------------
module pdm_capture_ctrl #(
   parameter int NUM_LINES     = 4,
   parameter int CLK_DIV       = 16,
   parameter int WARMUP_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [NUM_LINES-1:0]   ddr_data,
   output logic                   pdm_clk,
   output logic [2*NUM_LINES-1:0] sample_data,
   output logic                   sample_valid,
   input  logic                   sample_ready,
   output logic                   overflow,
   output logic [1:0]             state
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int WCNT_W = $clog2(WARMUP_CYCLES + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [WCNT_W-1:0] WCNT_SAT  = WCNT_W'(WARMUP_CYCLES);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WARMUP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } state_e;

   state_e                 state_q,  state_d;
   logic [DIV_W-1:0]       div_q,    div_d;
   logic                   pclk_q,   pclk_d;
   logic [WCNT_W-1:0]      wcnt_q,   wcnt_d;
   logic [2*NUM_LINES-1:0] data_q,   data_d;
   logic                   valid_q,  valid_d;
   logic                   ovf_q,    ovf_d;
   logic [NUM_LINES-1:0]   rise_q;

   logic                   tick;
   logic                   to_idle;
   logic [2*NUM_LINES-1:0] word;

   // Interleave the two phase samples into the output word layout.
   function automatic logic [2*NUM_LINES-1:0] pack_word(
      input logic [NUM_LINES-1:0] rise_bits,
      input logic [NUM_LINES-1:0] fall_bits
   );
      logic [2*NUM_LINES-1:0] w;
      w = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         w[2*i]   = rise_bits[i];
         w[2*i+1] = fall_bits[i];
      end
      return w;
   endfunction

   assign tick = (div_q == DIV_LAST);
   // The falling-phase mic is sampled straight off the line on the completing
   // cycle, so the word is assembled without a second phase register.
   assign word = pack_word(rise_q, ddr_data);
   // The unused encoding is treated like a disable so the FSM cannot lock up.
   assign to_idle = !enable ||
                    ((state_q != ST_IDLE) && (state_q != ST_WARMUP) && (state_q != ST_RUN));

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      pclk_d  = pclk_q;
      wcnt_d  = wcnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;

      if (to_idle) begin
         state_d = ST_IDLE;
         div_d   = '0;
         pclk_d  = 1'b0;
         wcnt_d  = '0;
         valid_d = 1'b0;
         ovf_d   = 1'b0;
      end else if (state_q == ST_IDLE) begin
         state_d = ST_WARMUP;
      end else begin
         div_d = tick ? '0 : div_q + DIV_W'(1);
         if (tick) begin
            pclk_d = ~pclk_q;
         end

         if (valid_q && sample_ready) begin
            valid_d = 1'b0;
         end

         // tick with pdm_clk low is the cycle before a rise: word completes.
         if (tick && !pclk_q) begin
            if (state_q == ST_WARMUP) begin
               if (wcnt_q != WCNT_SAT) begin
                  wcnt_d = wcnt_q + WCNT_W'(1);
               end
               // The word completing on this transition edge is still
               // warm-up data and is discarded with the rest.
               if (wcnt_q == WCNT_LAST) begin
                  state_d = ST_RUN;
               end
            end else if (!valid_q || sample_ready) begin
               data_d  = word;
               valid_d = 1'b1;
            end else begin
               ovf_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         pclk_q  <= 1'b0;
         wcnt_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         pclk_q  <= pclk_d;
         wcnt_q  <= wcnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   // Rising-phase sample: last cycle of the high phase. Any stale content is
   // overwritten before the first word that can reach the output.
   always_ff @(posedge clk) begin
      if ((state_q == ST_WARMUP || state_q == ST_RUN) && enable && tick && pclk_q) begin
         rise_q <= ddr_data;
      end
   end

   assign pdm_clk      = pclk_q;
   assign sample_data  = data_q;
   assign sample_valid = valid_q;
   assign overflow     = ovf_q;
   assign state        = state_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pdm_capture_ctrl
//
// Bench for pdm_capture_ctrl with NUM_LINES=4, CLK_DIV=2, WARMUP_CYCLES=4.
// The reference model tracks time since enable as a cycle count and derives
// pdm_clk, state and the capture instants from it arithmetically; a small
// valid/ready scoreboard follows the output handshake.
// -----------------------------------------------------------------------------
module tb_pdm_capture_ctrl;

   localparam int NL = 4;
   localparam int CD = 2;
   localparam int WU = 4;
   localparam int PER = 2 * CD;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [NL-1:0] ddr_data;
   logic          pdm_clk;
   logic [2*NL-1:0] sample_data;
   logic          sample_valid;
   logic          sample_ready;
   logic          overflow;
   logic [1:0]    state;

   pdm_capture_ctrl #(
      .NUM_LINES    (NL),
      .CLK_DIV      (CD),
      .WARMUP_CYCLES(WU)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .ddr_data    (ddr_data),
      .pdm_clk     (pdm_clk),
      .sample_data (sample_data),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .overflow    (overflow),
      .state       (state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model: mt = cycles since entering WARMUP (-1 while idle).
   int            mt    = -1;
   logic          mv    = 1'b0;
   logic [2*NL-1:0] md  = '0;
   logic          movf  = 1'b0;
   logic [NL-1:0] mrise = '0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int rises(input int t);
      return (t + CD) / PER;
   endfunction

   function automatic int exp_state();
      if (mt < 0) return 0;
      return (rises(mt) >= WU) ? 2 : 1;
   endfunction

   function automatic logic exp_pclk();
      if (mt < 0) return 1'b0;
      return 1'((mt / CD) % 2);
   endfunction

   function automatic logic [2*NL-1:0] mk_word(input logic [NL-1:0] rb, input logic [NL-1:0] fb);
      logic [2*NL-1:0] w;
      for (int i = 0; i < NL; i++) begin
         w[2*i]   = rb[i];
         w[2*i+1] = fb[i];
      end
      return w;
   endfunction

   task automatic model_step(input logic r, input logic e, input logic [NL-1:0] d, input logic rdy);
      int ph;
      if (!r) begin
         mt = -1; mv = 1'b0; md = '0; movf = 1'b0;
      end else if (!e) begin
         mt = -1; mv = 1'b0; movf = 1'b0;
      end else if (mt < 0) begin
         mt = 0;
      end else begin
         ph = mt % PER;
         if (ph == PER - 1) mrise = d;
         if (ph == CD - 1 && rises(mt) >= WU) begin
            if (!mv || rdy) begin
               md = mk_word(mrise, d);
               mv = 1'b1;
            end else begin
               movf = 1'b1;
            end
         end else if (mv && rdy) begin
            mv = 1'b0;
         end
         mt++;
      end
   endtask

   task automatic cycle(input logic r, input logic e, input logic [NL-1:0] d, input logic rdy);
      rst = r; enable = e; ddr_data = d; sample_ready = rdy;
      @(posedge clk);
      model_step(r, e, d, rdy);
      #1;
      check_val("state",   32'(state),        32'(exp_state()));
      check_val("pdm_clk", 32'(pdm_clk),      32'(exp_pclk()));
      check_val("valid",   32'(sample_valid), 32'(mv));
      check_val("ovf",     32'(overflow),     32'(movf));
      if (mv) check_val("data", 32'(sample_data), 32'(md));
      if (!r) check_val("rst_data", 32'(sample_data), 32'(0));
   endtask

   // High-phase all ones, low-phase all zeros, for the cycle now in progress.
   function automatic logic [NL-1:0] pattern_ddr();
      return exp_pclk() ? {NL{1'b1}} : {NL{1'b0}};
   endfunction

   int pulses;

   initial begin
      rst = 1'b0; enable = 1'b0; ddr_data = '0; sample_ready = 1'b0;

      // Reset held with random inputs.
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'($urandom), NL'($urandom), 1'($urandom));

      // Release with enable: warm-up, then the 0x55 pattern with ready high.
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         cycle(1'b1, 1'b1, pattern_ddr(), 1'b1);
         if (mt >= 20 && sample_valid) begin
            pulses++;
            check_val("word55", 32'(sample_data), 32'h55);
         end
      end
      check_val("pulse_cnt", 32'(pulses), 32'd10);

      // Downstream stalled for three pdm periods, then released.
      for (int i = 0; i < 3 * PER; i++) cycle(1'b1, 1'b1, NL'($urandom), 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, NL'($urandom), 1'b1);
      check_val("ovf_sticky", 32'(overflow), 32'd1);

      // Disable with a word pending (stall so valid is high), then re-enable.
      for (int i = 0; i < PER; i++) cycle(1'b1, 1'b1, NL'($urandom), 1'b0);
      cycle(1'b1, 1'b0, NL'($urandom), 1'b0);
      check_val("dis_state", 32'(state), 32'd0);

      // Ready only on the cycle each new word completes: back-to-back, no drop.
      for (int i = 0; i < 50; i++)
         cycle(1'b1, 1'b1, NL'($urandom), 1'(mt >= 0 && (mt % PER) == CD - 1));
      check_val("ovf_bb", 32'(overflow), 32'd0);

      // Single-cycle reset in RUN, warm-up repeats.
      cycle(1'b0, 1'b1, NL'($urandom), 1'b1);
      for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, NL'($urandom), 1'($urandom));

      // Fully random traffic with occasional disable and reset.
      for (int i = 0; i < 800; i++)
         cycle(1'($urandom_range(0, 149) != 0), 1'($urandom_range(0, 79) != 0),
               NL'($urandom), 1'($urandom_range(0, 2) != 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
